cfa_window5x5: RTL and testbench
================================

// Module: cfa_window5x5
// PURPOSE
//  Streaming 5x5 neighbourhood generator: the producer side of the equ1 window interface.
//  Accepts raster-order 12-bit Bayer CFA pixels, buffers four prior lines and presents
//  the 25 taps e1t1..e5t5 plus a one-cycle start strobe per complete window.
//  Sits between the sensor/file pixel source and the equ1 gradient stages.
// PARAMETERS
//  PIX_W       12   pixel width, bits
//  IMG_WIDTH   64   pixels per line (>=5)
//  IMG_HEIGHT  64   lines per frame (>=5)
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      synchronous active-high reset
//  pix_in       in   PIX_W  raster pixel, line-major, left to right
//  pix_valid    in   1      pix_in accepted on every cycle this is high (no backpressure)
//  start        out  1      one-cycle pulse: e1t1..e5t5 hold a new complete window
//  e1t1..e5t5   out  PIX_W  window taps; eR = row R (e1 oldest/top), tC = col C (t1 leftmost)
//  frame_done   out  1      one-cycle pulse after last pixel of the frame is accepted
// BEHAVIOUR
//  - Reset: start=0, frame_done=0, all taps=0, col/row counters=0. Line-buffer RAM not cleared.
//  - Counters: col 0..IMG_WIDTH-1, row 0..IMG_HEIGHT-1; advance only on pix_valid.
//    col wraps to 0 and row increments at col=IMG_WIDTH-1; both wrap to 0 at frame end.
//  - Line buffers: 4 delay lines, depth IMG_WIDTH; on pix_valid, column words shift
//    pix_in -> LB0 -> LB1 -> LB2 -> LB3 (one word per accept).
//  - Window: 5x5 register array; on pix_valid, all columns shift left (t1 <- t2 ... t4 <- t5),
//    new t5 column = {LB3 out, LB2 out, LB1 out, LB0 out, pix_in} into e1..e5.
//  - Latency: taps and start update 1 cycle after the accepting edge of pixel (row,col).
//  - start=1 for exactly that cycle iff the accepted pixel had row>=4 and col>=4;
//    window centre e3t3 is then pixel (row-2, col-2). No windows straddle line edges.
//  - pix_valid=0: taps hold, start=0, counters hold. Gaps of any length are legal.
//  - frame_done pulses in the same cycle as start for pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
//  - Windows per frame: (IMG_HEIGHT-4)*(IMG_WIDTH-4).
//  - rst mid-frame: next cycle start=0, counters=0; the next 4 full lines are refilled before
//    any start, so stale RAM contents are never emitted.
//  - Pure datapath copy: no arithmetic on pixel values; widths preserved at PIX_W.
// CONFIGURATION
//  CFA_PHASE_OUT_EN defined: adds output cfa_phase [1:0] = {row[0], col[0]} of the centre
//    pixel (row-2, col-2), registered alongside taps; reset 2'b00; holds when pix_valid=0.
//  Not defined: port absent, no extra logic; all other behaviour identical.
// STRUCTURE
//  - Shared package cfa_pkg: PIX_W, default IMG_WIDTH/IMG_HEIGHT, window size constant 5,
//    centre offset constant 2.
//  - One sub-module cfa_line_buffer: single delay line, depth IMG_WIDTH, shift-enable input,
//    circular-pointer RAM; instantiated 4 times. Counters, window array, strobes in top.
// TESTING (IMG_WIDTH=8, IMG_HEIGHT=8, pixel value = row*16+col)
//  1 Full frame, pix_valid=1 continuous -> first start 1 cycle after pixel 36 (row4,col4):
//    e1t1=0x00, e3t3=0x22, e5t5=0x44; exactly 16 start pulses; frame_done with last (0x77 at e5t5).
//  2 Same frame with pix_valid toggling 1,0,0 -> identical tap sequence at each start,
//    taps and counters frozen during gaps, never start on a pix_valid=0 cycle.
//  3 Columns 0..3 of any row -> start stays 0; window never mixes col 7 of row r with row r+1.
//  4 Two back-to-back frames -> second frame emits 16 windows, first equal to case 1 window.
//  5 rst asserted at pixel (5,3) -> next cycle start=0, taps=0; restart frame yields case 1 results.
//  6 CFA_PHASE_OUT_EN defined -> cfa_phase=2'b00 on first window, 2'b01 on second, 2'b10 on
//    first window of row5; build without macro compiles with port absent.

Source files
------------

// File: rtl/cfa_pkg.sv
// Shared constants for the 5x5 CFA window generator: pixel width, default
// frame geometry and window shape.
package cfa_pkg;

   localparam int PIX_W          = 12;
   localparam int DEF_IMG_WIDTH  = 64;
   localparam int DEF_IMG_HEIGHT = 64;
   localparam int WIN_N          = 5;
   localparam int CENTRE_OFF     = 2;
   localparam int LB_N           = WIN_N - 1;

endpackage

// File: rtl/cfa_line_buffer.sv
// Single line delay: a word written on a shift returns DEPTH shifts later.
// The storage is a circular-pointer RAM, and its contents are not cleared by reset.
module cfa_line_buffer #(
   parameter int DEPTH = 64,
   parameter int W     = 12
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         shift_en_i,
   input  logic [W-1:0] din_i,
   output logic [W-1:0] dout_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0] ptr_q, ptr_d;

   // The read happens before the write at the same slot, so dout is the word from DEPTH shifts ago
   assign dout_o = mem_q[ptr_q];

   always_comb begin
      ptr_d = ptr_q;
      if (shift_en_i) begin
         if (ptr_q == PTR_W'(DEPTH - 1)) ptr_d = '0;
         else                            ptr_d = ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end

   always_ff @(posedge clk) begin
      if (shift_en_i) mem_q[ptr_q] <= din_i;
   end

endmodule

// File: rtl/cfa_window5x5.sv
// Streaming 5x5 Bayer neighbourhood generator: four line delays feed a 5x5 tap array.
// Optional build macro CFA_PHASE_OUT_EN adds the cfa_phase output for the centre pixel.
module cfa_window5x5
   import cfa_pkg::*;
#(
   parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
   parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PIX_W-1:0] pix_in,
   input  logic             pix_valid,
   output logic             start,
   output logic             frame_done,
   output logic [PIX_W-1:0] e1t1, e1t2, e1t3, e1t4, e1t5,
   output logic [PIX_W-1:0] e2t1, e2t2, e2t3, e2t4, e2t5,
   output logic [PIX_W-1:0] e3t1, e3t2, e3t3, e3t4, e3t5,
   output logic [PIX_W-1:0] e4t1, e4t2, e4t3, e4t4, e4t5,
   output logic [PIX_W-1:0] e5t1, e5t2, e5t3, e5t4, e5t5
`ifdef CFA_PHASE_OUT_EN
   ,
   output logic [1:0]       cfa_phase
`endif
);

   localparam int COL_W = $clog2(IMG_WIDTH);
   localparam int ROW_W = $clog2(IMG_HEIGHT);

   logic [COL_W-1:0] col_q, col_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic             start_q, start_d;
   logic             frame_done_q, frame_done_d;
   logic [PIX_W-1:0] win_q [WIN_N][WIN_N];
   logic [PIX_W-1:0] win_d [WIN_N][WIN_N];
   logic [PIX_W-1:0] lb_in  [LB_N];
   logic [PIX_W-1:0] lb_out [LB_N];
   logic [PIX_W-1:0] new_col [WIN_N];
   logic             last_col, last_row;

   always_comb begin
      lb_in[0] = pix_in;
      for (int k = 1; k < LB_N; k++) lb_in[k] = lb_out[k-1];
   end

   for (genvar g = 0; g < LB_N; g++) begin : g_lb
      cfa_line_buffer #(.DEPTH(IMG_WIDTH), .W(PIX_W)) u_lb (
         .clk        (clk),
         .rst        (rst),
         .shift_en_i (pix_valid),
         .din_i      (lb_in[g]),
         .dout_o     (lb_out[g])
      );
   end

   // Oldest line (deepest delay) lands in the top row e1
   always_comb begin
      for (int r = 0; r < LB_N; r++) new_col[r] = lb_out[LB_N-1-r];
      new_col[WIN_N-1] = pix_in;
   end

   assign last_col = (col_q == COL_W'(IMG_WIDTH - 1));
   assign last_row = (row_q == ROW_W'(IMG_HEIGHT - 1));

   always_comb begin
      col_d        = col_q;
      row_d        = row_q;
      win_d        = win_q;
      start_d      = 1'b0;
      frame_done_d = 1'b0;
      if (pix_valid) begin
         for (int r = 0; r < WIN_N; r++) begin
            for (int c = 0; c < WIN_N-1; c++) win_d[r][c] = win_q[r][c+1];
            win_d[r][WIN_N-1] = new_col[r];
         end
         start_d      = (row_q >= ROW_W'(WIN_N-1)) && (col_q >= COL_W'(WIN_N-1));
         frame_done_d = last_col && last_row;
         if (last_col) begin
            col_d = '0;
            row_d = last_row ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col_q        <= '0;
         row_q        <= '0;
         start_q      <= 1'b0;
         frame_done_q <= 1'b0;
         for (int r = 0; r < WIN_N; r++)
            for (int c = 0; c < WIN_N; c++) win_q[r][c] <= '0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         start_q      <= start_d;
         frame_done_q <= frame_done_d;
         win_q        <= win_d;
      end
   end

`ifdef CFA_PHASE_OUT_EN
   // Parity of (row-2, col-2) equals parity of (row, col) shifted by the centre offset
   logic [1:0] phase_q, phase_d;

   always_comb begin
      phase_d = phase_q;
      if (pix_valid)
         phase_d = {row_q[0] ^ 1'(CENTRE_OFF % 2), col_q[0] ^ 1'(CENTRE_OFF % 2)};
   end

   always_ff @(posedge clk) begin
      if (rst) phase_q <= 2'b00;
      else     phase_q <= phase_d;
   end

   assign cfa_phase = phase_q;
`endif

   assign start      = start_q;
   assign frame_done = frame_done_q;

   assign e1t1 = win_q[0][0];  assign e1t2 = win_q[0][1];  assign e1t3 = win_q[0][2];
   assign e1t4 = win_q[0][3];  assign e1t5 = win_q[0][4];
   assign e2t1 = win_q[1][0];  assign e2t2 = win_q[1][1];  assign e2t3 = win_q[1][2];
   assign e2t4 = win_q[1][3];  assign e2t5 = win_q[1][4];
   assign e3t1 = win_q[2][0];  assign e3t2 = win_q[2][1];  assign e3t3 = win_q[2][2];
   assign e3t4 = win_q[2][3];  assign e3t5 = win_q[2][4];
   assign e4t1 = win_q[3][0];  assign e4t2 = win_q[3][1];  assign e4t3 = win_q[3][2];
   assign e4t4 = win_q[3][3];  assign e4t5 = win_q[3][4];
   assign e5t1 = win_q[4][0];  assign e5t2 = win_q[4][1];  assign e5t3 = win_q[4][2];
   assign e5t4 = win_q[4][3];  assign e5t5 = win_q[4][4];

endmodule

// File: tb/tb_cfa_window5x5.sv
// Bench for cfa_window5x5 on an 8x8 frame: the model keeps the raster history since
// reset and derives every tap, strobe and phase from pixel positions.
module tb_cfa_window5x5;

   localparam int W = 8;
   localparam int H = 8;
   localparam int N = W * H;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [11:0] pix_in = '0;
   logic        pix_valid = 1'b0;
   logic        start, frame_done;
   logic [11:0] e1t1, e1t2, e1t3, e1t4, e1t5;
   logic [11:0] e2t1, e2t2, e2t3, e2t4, e2t5;
   logic [11:0] e3t1, e3t2, e3t3, e3t4, e3t5;
   logic [11:0] e4t1, e4t2, e4t3, e4t4, e4t5;
   logic [11:0] e5t1, e5t2, e5t3, e5t4, e5t5;
`ifdef CFA_PHASE_OUT_EN
   logic [1:0]  cfa_phase;
`endif

   always #5 clk = ~clk;

   cfa_window5x5 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid),
      .start(start), .frame_done(frame_done),
      .e1t1(e1t1), .e1t2(e1t2), .e1t3(e1t3), .e1t4(e1t4), .e1t5(e1t5),
      .e2t1(e2t1), .e2t2(e2t2), .e2t3(e2t3), .e2t4(e2t4), .e2t5(e2t5),
      .e3t1(e3t1), .e3t2(e3t2), .e3t3(e3t3), .e3t4(e3t4), .e3t5(e3t5),
      .e4t1(e4t1), .e4t2(e4t2), .e4t3(e4t3), .e4t4(e4t4), .e4t5(e4t5),
      .e5t1(e5t1), .e5t2(e5t2), .e5t3(e5t3), .e5t4(e5t4), .e5t5(e5t5)
`ifdef CFA_PHASE_OUT_EN
      , .cfa_phase(cfa_phase)
`endif
   );

   logic [299:0] dut_win;
   assign dut_win = {e1t1, e1t2, e1t3, e1t4, e1t5, e2t1, e2t2, e2t3, e2t4, e2t5,
                     e3t1, e3t2, e3t3, e3t4, e3t5, e4t1, e4t2, e4t3, e4t4, e4t5,
                     e5t1, e5t2, e5t3, e5t4, e5t5};

   int          n_checks = 0;
   int          n_errors = 0;
   int          n_starts = 0;
   logic [11:0] hist[$];
   logic        exp_start = 1'b0;
   logic        exp_fd = 1'b0;
   logic [1:0]  exp_phase = 2'b00;

   task automatic check(input string tag, input logic [299:0] obs, input logic [299:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, update the model at the edge, compare half a cycle later
   task automatic step(input logic v, input logic [11:0] p, input logic r_in);
      int fp, r, c, k, s, m, idx;
      logic [299:0] exp_win, mask;
      rst = r_in; pix_valid = v; pix_in = p;
      @(posedge clk);
      if (r_in) begin
         hist.delete();
         exp_start = 1'b0; exp_fd = 1'b0; exp_phase = 2'b00;
      end else if (v) begin
         fp = hist.size() % N;
         r = fp / W; c = fp % W;
         hist.push_back(p);
         exp_start = (r >= 4) && (c >= 4);
         exp_fd    = (fp == N - 1);
         exp_phase = {r[0], c[0]};
      end else begin
         exp_start = 1'b0; exp_fd = 1'b0;
      end
      @(negedge clk);
      check("start", 300'(start), 300'(exp_start));
      check("frame_done", 300'(frame_done), 300'(exp_fd));
      if (start) n_starts++;
      // Tap (i,j) was loaded by accept s; its row i came through (4-i) line delays
      exp_win = '0; mask = '0;
      k = hist.size();
      for (int i = 0; i < 5; i++) begin
         for (int j = 0; j < 5; j++) begin
            idx = (24 - (i * 5 + j)) * 12;
            s = k - 1 - (4 - j);
            if (s < 0) begin
               mask[idx +: 12] = 12'hfff;
            end else begin
               m = s - (4 - i) * W;
               if (m >= 0) begin
                  mask[idx +: 12]    = 12'hfff;
                  exp_win[idx +: 12] = hist[m];
               end
            end
         end
      end
      if (mask != '0) check("taps", dut_win & mask, exp_win & mask);
`ifdef CFA_PHASE_OUT_EN
      check("cfa_phase", 300'(cfa_phase), 300'(exp_phase));
`endif
   endtask

   task automatic ramp_frame();
      n_starts = 0;
      for (int n = 0; n < N; n++) begin
         step(1'b1, 12'((n / W) * 16 + (n % W)), 1'b0);
         if (n == 36) begin
            check("first_e1t1", 300'(e1t1), 300'(12'h000));
            check("first_e3t3", 300'(e3t3), 300'(12'h022));
            check("first_e5t5", 300'(e5t5), 300'(12'h044));
         end
      end
      check("last_e5t5", 300'(e5t5), 300'(12'h077));
      check("last_frame_done", 300'(frame_done), 300'(1'b1));
      check("ramp_windows", 300'(n_starts), 300'(16));
   endtask

   initial begin
      step(1'b0, 12'h0, 1'b1);
      step(1'b1, 12'h5a5, 1'b1);
      check("reset_taps", dut_win, '0);

      ramp_frame();

      // Accept every third cycle with random junk on the idle cycles
      n_starts = 0;
      for (int n = 0; n < N; n++) begin
         step(1'b1, 12'((n / W) * 16 + (n % W)), 1'b0);
         step(1'b0, 12'($urandom), 1'b0);
         step(1'b0, 12'($urandom), 1'b0);
      end
      check("gap_windows", 300'(n_starts), 300'(16));

      // Two back-to-back random frames with random gaps
      n_starts = 0;
      for (int n = 0; n < 2 * N; ) begin
         if ($urandom_range(0, 3) != 0) begin
            step(1'b1, 12'($urandom), 1'b0);
            n++;
         end else begin
            step(1'b0, 12'($urandom), 1'b0);
         end
      end
      check("random_windows", 300'(n_starts), 300'(32));

      // Reset lands on pixel (5,3), then a clean frame must match the first
      for (int n = 0; n < 43; n++) step(1'b1, 12'($urandom), 1'b0);
      step(1'b1, 12'h053, 1'b1);
      check("midreset_taps", dut_win, '0);
      ramp_frame();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
